// File: rtl/imem_boot_loader_if.sv
// Bus bundle for imem_boot_loader: load control, byte stream and instruction-memory port.
// The chk_err signal exists only when CHECKSUM_EN is defined.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [8:0]        word_count;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic [ADDR_W-1:0] pc_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic              cpu_hold;
  logic              busy;
  logic              done;
`ifdef CHECKSUM_EN
  logic              chk_err;
`endif

  modport master (
    output start, word_count, s_valid, s_data, pc_addr,
    input  s_ready, mem_we, mem_a, mem_wd, cpu_hold, busy, done
`ifdef CHECKSUM_EN
    , input chk_err
`endif
  );

  modport slave (
    input  start, word_count, s_valid, s_data, pc_addr,
    output s_ready, mem_we, mem_a, mem_wd, cpu_hold, busy, done
`ifdef CHECKSUM_EN
    , output chk_err
`endif
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: packs a little-endian byte stream into 32-bit words written from address 0,
// holding the CPU meanwhile. Define CHECKSUM_EN to add a trailing mod-256 checksum byte.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic               clk,
  input  logic               rst,
  imem_boot_loader_if.slave  bus
);
  localparam int         IDX_W   = ADDR_W - 2;
  localparam logic [8:0] MAX_CNT = 9'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2
`ifdef CHECKSUM_EN
    , CHK = 2'd3
`endif
  } state_t;

  state_t            state_r;
  logic [8:0]        cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [1:0]        byte_r;
  logic [DATA_W-1:0] wd_r;
  logic              we_r;
  logic              ready_r;
  logic              hold_r;
  logic              busy_r;
  logic              done_r;
  logic [8:0]        clamp_cnt_s;
  logic              last_s;

`ifdef CHECKSUM_EN
  logic [7:0]        sum_r;
  logic              chk_err_r;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign bus.chk_err = chk_err_r;
`endif

  // Clamping the count keeps word_idx from ever wrapping past the top of memory.
  assign clamp_cnt_s = (bus.word_count > MAX_CNT) ? MAX_CNT : bus.word_count;
  assign last_s      = (9'(idx_r) == (cnt_r - 9'd1));

  assign bus.mem_a    = busy_r ? {idx_r, 2'b00} : bus.pc_addr;
  assign bus.mem_we   = we_r;
  assign bus.mem_wd   = wd_r;
  assign bus.s_ready  = ready_r;
  assign bus.cpu_hold = hold_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

  // Load sequencer; every output except the address mux is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 9'd0;
      idx_r     <= '0;
      byte_r    <= 2'd0;
      wd_r      <= '0;
      we_r      <= 1'b0;
      ready_r   <= 1'b0;
      hold_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef CHECKSUM_EN
      sum_r     <= 8'd0;
      chk_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r  <= clamp_cnt_s;
            idx_r  <= '0;
            byte_r <= 2'd0;
            done_r <= 1'b0;
`ifdef CHECKSUM_EN
            sum_r     <= 8'd0;
            chk_err_r <= 1'b0;
            busy_r    <= 1'b1;
            hold_r    <= 1'b1;
            ready_r   <= 1'b1;
            state_r   <= (clamp_cnt_s == 9'd0) ? CHK : RECV;
`else
            if (clamp_cnt_s == 9'd0) begin
              done_r <= 1'b1;
            end else begin
              busy_r  <= 1'b1;
              hold_r  <= 1'b1;
              ready_r <= 1'b1;
              state_r <= RECV;
            end
`endif
          end
        end
        RECV: begin
          // s_ready is held high throughout RECV, so s_valid alone marks a handshake.
          if (bus.s_valid) begin
            wd_r[{byte_r, 3'b000} +: 8] <= bus.s_data;
            byte_r <= byte_r + 2'd1;
`ifdef CHECKSUM_EN
            sum_r  <= sum8(sum_r, bus.s_data);
`endif
            if (byte_r == 2'd3) begin
              ready_r <= 1'b0;
              we_r    <= 1'b1;
              state_r <= WRITE;
            end
          end
        end
        WRITE: begin
          we_r <= 1'b0;
          if (last_s) begin
`ifdef CHECKSUM_EN
            ready_r <= 1'b1;
            state_r <= CHK;
`else
            busy_r  <= 1'b0;
            hold_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= IDLE;
`endif
          end else begin
            idx_r   <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            ready_r <= 1'b1;
            state_r <= RECV;
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (bus.s_valid) begin
            chk_err_r <= (bus.s_data != sum_r);
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            hold_r    <= 1'b0;
            done_r    <= 1'b1;
            state_r   <= IDLE;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: a transaction-level model (bytes accepted vs words
// written) predicts every output each cycle; literal checks pin timing and memory contents.
module tb_imem_boot_loader;
  localparam int ADDR_W = 10;
`ifdef CHECKSUM_EN
  localparam int T1_LEN = 86;
  localparam int T3_LEN = 1;
`else
  localparam int T1_LEN = 85;
  localparam int T3_LEN = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();
  imem_boot_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_pulses = 0;
  bit pc_rand = 1'b0;
  logic [31:0] ram [0:255];

  logic [31:0] t1 [$] = '{32'h010000df, 32'h0800006f, 32'h00000013, 32'h00100093,
                          32'h00200113, 32'h002081b3, 32'h40208233, 32'h0041a2b3,
                          32'h00512023, 32'h00012303, 32'h00430393, 32'hfe731ee3,
                          32'h00000513, 32'h00150513, 32'hfff00593, 32'h00b50633,
                          32'h00008067};

  // Model: a load is a count of words; writes trail accepted bytes by one word.
  bit         m_load, m_chk, m_done, m_err;
  int         m_cnt, m_acc, m_wr;
  logic [7:0] m_sum;
  logic [7:0] m_bytes [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pend();
    return m_load && !m_chk && (m_acc == 4 * (m_wr + 1));
  endfunction

  function automatic bit m_ready();
    return m_load && (m_chk || !m_pend());
  endfunction

  function automatic logic [9:0] m_addr();
    int idx;
    if (!m_load) return bus.pc_addr;
    idx = m_chk ? ((m_cnt > 0) ? m_cnt - 1 : 0) : m_wr;
    return 10'(4 * idx);
  endfunction

  function automatic logic [31:0] m_word();
    int b;
    b = 4 * m_wr;
    return {m_bytes[b+3], m_bytes[b+2], m_bytes[b+1], m_bytes[b]};
  endfunction

  task automatic model_step();
    bit pend;
    bit rdy;
    pend = m_pend();
    rdy  = m_ready();
    if (!m_load) begin
      if (bus.start) begin
        m_cnt = (bus.word_count > 9'd256) ? 256 : int'(bus.word_count);
        m_acc = 0; m_wr = 0; m_done = 1'b0; m_sum = 8'd0; m_err = 1'b0;
        m_bytes.delete();
`ifdef CHECKSUM_EN
        m_load = 1'b1;
        m_chk  = (m_cnt == 0);
`else
        if (m_cnt == 0) m_done = 1'b1;
        else begin m_load = 1'b1; m_chk = 1'b0; end
`endif
      end
    end else if (pend) begin
      m_wr++;
      if (m_wr == m_cnt) begin
`ifdef CHECKSUM_EN
        m_chk = 1'b1;
`else
        m_load = 1'b0;
        m_done = 1'b1;
`endif
      end
    end else if (rdy && bus.s_valid) begin
      if (m_chk) begin
        m_err = (bus.s_data != m_sum);
        m_load = 1'b0; m_chk = 1'b0; m_done = 1'b1;
      end else begin
        m_bytes.push_back(bus.s_data);
        m_acc++;
        m_sum += bus.s_data;
      end
    end
  endtask

  always @(posedge clk) if (bus.mem_we) ram[bus.mem_a[9:2]] <= bus.mem_wd;

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_load = 1'b0; m_chk = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check("busy", bus.busy, m_load);
      check("cpu_hold", bus.cpu_hold, m_load);
      check("done", bus.done, m_done);
      check("s_ready", bus.s_ready, m_ready());
      check("mem_we", bus.mem_we, m_pend());
      check("mem_a", bus.mem_a, m_addr());
      if (m_pend()) check("mem_wd", bus.mem_wd, m_word());
`ifdef CHECKSUM_EN
      check("chk_err", bus.chk_err, m_err);
`endif
      if (bus.mem_we) we_pulses++;
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (pc_rand) bus.pc_addr = 10'($urandom);
  end

  // Runs one load; stop_at >= 0 abandons the stream after that many accepted bytes.
  task automatic load(input logic [31:0] w [$], input int wc, input int gap, input bit bad,
                      input int stop_at, output int len);
    logic [7:0] b [$];
    logic [7:0] s;
    int n, i, lim, budget, t0;
    bit hs;
    s = 8'd0; i = 0; len = -1;
    n = (wc > 256) ? 256 : wc;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 4; j++) begin
        b.push_back(8'(w[k] >> (8 * j)));
        s += 8'(w[k] >> (8 * j));
      end
`ifdef CHECKSUM_EN
    b.push_back(bad ? (s ^ 8'h5a) : s);
`endif
    bus.word_count = 9'(wc);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    t0 = cyc;
    lim = (stop_at >= 0) ? stop_at : b.size();
    budget = 20 * b.size() + 50;
    while (i < lim && budget > 0) begin
      bus.s_valid = ($urandom_range(99) >= gap);
      bus.s_data  = b[i];
      @(negedge clk);
      hs = bus.s_valid && bus.s_ready;
      @(posedge clk); #2;
      if (hs) i++;
      budget--;
    end
    bus.s_valid = 1'b0;
    if (stop_at < 0) begin
      @(negedge clk);
      while (!bus.done && budget > 0) begin @(negedge clk); budget--; end
      check("load_done", bus.done, 1'b1);
      len = cyc - t0;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    int len, we0;
    logic [31:0] rw [$];
    bus.start = 1'b0; bus.word_count = 9'd0; bus.s_valid = 1'b0; bus.s_data = 8'd0;
    bus.pc_addr = 10'h2a4;
    repeat (3) @(posedge clk); #2;
    check("rst_mem_a", bus.mem_a, 10'h2a4);
    check("rst_mem_wd", bus.mem_wd, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_s_ready", bus.s_ready, 1'b0);
    rst = 1'b0;
    @(posedge clk); #2;
    pc_rand = 1'b1;

    // T1 basic load
    we0 = we_pulses;
    load(t1, 17, 0, 1'b0, -1, len);
    check("t1_len", len, T1_LEN);
    check("t1_pulses", we_pulses - we0, 17);
    check("t1_hold", bus.cpu_hold, 1'b0);
    for (int k = 0; k < 17; k++) check("t1_ram", ram[k], t1[k]);

    // T2 stream gaps with a start pulse while busy
    for (int k = 0; k < 20; k++) ram[k] = 32'h0;
    we0 = we_pulses;
    fork
      load(t1, 17, 40, 1'b0, -1, len);
      begin
        repeat (30) @(posedge clk); #3;
        bus.start = 1'b1; bus.word_count = 9'd3;
        @(posedge clk); #3;
        bus.start = 1'b0;
      end
    join
    check("t2_pulses", we_pulses - we0, 17);
    for (int k = 0; k < 17; k++) check("t2_ram", ram[k], t1[k]);
    check("t2_no_extra", ram[17], 32'h0);

    // T5 pass-through after done
    pc_rand = 1'b0;
    @(posedge clk); #3;
    bus.pc_addr = 10'h010;
    #1;
    check("t5_mem_a", bus.mem_a, 10'h010);
    check("t5_word4", ram[bus.mem_a[9:2]], 32'h00200113);
    pc_rand = 1'b1;

    // T3 zero count
    we0 = we_pulses;
    load(t1, 0, 0, 1'b0, -1, len);
    check("t3_len", len, T3_LEN);
    repeat (3) @(posedge clk); #2;
    check("t3_pulses", we_pulses - we0, 0);

    // Randomized loads, including the clamp at the memory capacity
    for (int r = 0; r < 6; r++) begin
      int wc;
      rw.delete();
      wc = (r == 5) ? 300 : $urandom_range(8, 1);
      for (int k = 0; k < 256; k++) rw.push_back($urandom);
      we0 = we_pulses;
      load(rw, wc, $urandom_range(60, 0), 1'b0, -1, len);
      check("rand_pulses", we_pulses - we0, (wc > 256) ? 256 : wc);
      check("rand_first", ram[0], rw[0]);
      if (wc > 256) check("clamp_last", ram[255], rw[255]);
    end

    // T4 reset after two bytes of word 3
    pc_rand = 1'b0;
    bus.pc_addr = 10'h0c8;
    rw.delete();
    for (int k = 0; k < 5; k++) rw.push_back($urandom);
    load(rw, 5, 0, 1'b0, 14, len);
    rst = 1'b1;
    #1;
    check("t4_we", bus.mem_we, 1'b0);
    check("t4_busy", bus.busy, 1'b0);
    check("t4_done", bus.done, 1'b0);
    check("t4_hold", bus.cpu_hold, 1'b0);
    check("t4_mem_a", bus.mem_a, 10'h0c8);
    repeat (2) @(posedge clk); #2;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.pc_addr = 10'(4 * k);
      #1;
      check("t4_keep", ram[bus.mem_a[9:2]], rw[k]);
    end
    @(posedge clk); #2;

`ifdef CHECKSUM_EN
    // T6 checksum good then bad
    load(t1, 3, 20, 1'b0, -1, len);
    check("t6_good", bus.chk_err, 1'b0);
    load(t1, 3, 20, 1'b1, -1, len);
    check("t6_bad", bus.chk_err, 1'b1);
    check("t6_done", bus.done, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
